// File: rtl/axis_dot_param.sv
// -----------------------------------------------------------------------------
// axis_dot_param
//
// Runtime-loadable fixed-point matrix-vector engine on AXI4-Stream.
// A single input stream carries two frame types, selected by TUSER on the
// first word of the frame:
//   TUSER=1 : weight frame, IN_SIZE*OUT_SIZE words, row-major W[r][c]
//   TUSER=0 : vector frame, IN_SIZE words x[0..IN_SIZE-1]
// Each vector frame produces one OUT_SIZE-word result frame
//   y[r] = sat(round(sum_c x[c]*W[r][c] >> FRAC_W)),
// computed by one MAC with a registered product, one row at a time.
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   INPUT_AXIS_*           slave stream (TDATA, TUSER, TLAST, TVALID, TREADY)
//   OUTPUT_AXIS_*          master stream (TDATA, TLAST, TVALID, TREADY)
//   frame_err              sticky framing error (short or unterminated frame)
//   clear_err              synchronous clear of frame_err
// -----------------------------------------------------------------------------
module axis_dot_param #(
   parameter int IN_SIZE  = 20,
   parameter int OUT_SIZE = 10,
   parameter int DATA_W   = 16,
   parameter int FRAC_W   = 12
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic [DATA_W-1:0] INPUT_AXIS_TDATA,
   input  logic              INPUT_AXIS_TUSER,
   input  logic              INPUT_AXIS_TLAST,
   input  logic              INPUT_AXIS_TVALID,
   output logic              INPUT_AXIS_TREADY,
   output logic [DATA_W-1:0] OUTPUT_AXIS_TDATA,
   output logic              OUTPUT_AXIS_TLAST,
   output logic              OUTPUT_AXIS_TVALID,
   input  logic              OUTPUT_AXIS_TREADY,
   output logic              frame_err,
   input  logic              clear_err
);

   localparam int NW    = IN_SIZE * OUT_SIZE;
   localparam int WA_W  = (NW > 1) ? $clog2(NW) : 1;
   localparam int X_W   = $clog2(IN_SIZE);
   localparam int K_W   = $clog2(IN_SIZE + 2);
   localparam int R_W   = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
   localparam int P_W   = 2 * DATA_W;
   localparam int ACC_W = 2 * DATA_W + $clog2(IN_SIZE);

   // Rounding and saturation run one bit wider than the accumulator so the
   // half-LSB addition can never wrap.
   localparam logic signed [ACC_W:0] RND     = {{ACC_W{1'b0}}, 1'b1} << (FRAC_W - 1);
   localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_W,
      S_RECV_VEC,
      S_COMPUTE,
      S_SEND
   } state_t;

   state_t r_state;
   state_t w_state_next;

   // storage
   logic signed [DATA_W-1:0] r_w [NW];
   logic signed [DATA_W-1:0] r_x [IN_SIZE];

   // control / datapath registers
   logic [WA_W-1:0]          r_cnt;
   logic [K_W-1:0]           r_k;
   logic [R_W-1:0]           r_row;
   logic [WA_W-1:0]          r_base;
   logic signed [P_W-1:0]    r_prod;
   logic signed [ACC_W-1:0]  r_acc;
   logic                     r_tready;
   logic                     r_tvalid;
   logic                     r_tlast;
   logic [DATA_W-1:0]        r_tdata;
   logic                     r_err;

   // combinational
   logic                     w_hs_in;
   logic                     w_hs_out;
   logic                     w_err;
   logic                     w_w_we;
   logic                     w_x_we;
   logic [WA_W-1:0]          w_w_addr;
   logic [X_W-1:0]           w_x_addr;
   logic [X_W-1:0]           w_k_x;
   logic [WA_W-1:0]          w_w_rd;
   logic signed [P_W-1:0]    w_xe;
   logic signed [P_W-1:0]    w_we;
   logic signed [P_W-1:0]    w_prod;
   logic signed [ACC_W-1:0]  w_prod_ext;
   logic signed [ACC_W:0]    w_acc_rnd;
   logic signed [ACC_W:0]    w_shift;
   logic [DATA_W-1:0]        w_sat;
   logic                     w_last_row;

   assign INPUT_AXIS_TREADY  = r_tready;
   assign OUTPUT_AXIS_TDATA  = r_tdata;
   assign OUTPUT_AXIS_TLAST  = r_tlast;
   assign OUTPUT_AXIS_TVALID = r_tvalid;
   assign frame_err          = r_err;

   assign w_hs_in    = INPUT_AXIS_TVALID && r_tready;
   assign w_hs_out   = r_tvalid && OUTPUT_AXIS_TREADY;
   assign w_last_row = (r_row == R_W'(OUT_SIZE - 1));

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_err        = 1'b0;
      w_w_we       = 1'b0;
      w_x_we       = 1'b0;
      w_w_addr     = r_cnt;
      w_x_addr     = X_W'(r_cnt);
      case (r_state)
         S_IDLE: begin
            w_w_addr = '0;
            w_x_addr = '0;
            if (w_hs_in) begin
               w_w_we = INPUT_AXIS_TUSER;
               w_x_we = !INPUT_AXIS_TUSER;
               // Every frame is at least two words, so TLAST here is short.
               if (INPUT_AXIS_TLAST) w_err = 1'b1;
               else w_state_next = INPUT_AXIS_TUSER ? S_LOAD_W : S_RECV_VEC;
            end
         end
         S_LOAD_W: begin
            if (w_hs_in) begin
               w_w_we = 1'b1;
               if (r_cnt == WA_W'(NW - 1)) begin
                  w_state_next = S_IDLE;
                  w_err        = !INPUT_AXIS_TLAST;
               end else if (INPUT_AXIS_TLAST) begin
                  w_state_next = S_IDLE;
                  w_err        = 1'b1;
               end
            end
         end
         S_RECV_VEC: begin
            if (w_hs_in) begin
               w_x_we = 1'b1;
               if (r_cnt == WA_W'(IN_SIZE - 1)) begin
                  w_state_next = S_COMPUTE;
                  w_err        = !INPUT_AXIS_TLAST;
               end else if (INPUT_AXIS_TLAST) begin
                  w_state_next = S_IDLE;
                  w_err        = 1'b1;
               end
            end
         end
         S_COMPUTE: begin
            if (r_k == K_W'(IN_SIZE + 1)) w_state_next = S_SEND;
         end
         S_SEND: begin
            if (w_hs_out) w_state_next = w_last_row ? S_IDLE : S_COMPUTE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- storage
   genvar gi;
   generate
      for (gi = 0; gi < NW; gi++) begin : g_w
         always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn)                              r_w[gi] <= '0;
            else if (w_w_we && w_w_addr == WA_W'(gi)) r_w[gi] <= INPUT_AXIS_TDATA;
         end
      end
      for (gi = 0; gi < IN_SIZE; gi++) begin : g_x
         always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn)                             r_x[gi] <= '0;
            else if (w_x_we && w_x_addr == X_W'(gi)) r_x[gi] <= INPUT_AXIS_TDATA;
         end
      end
   endgenerate

   // ---------------------------------------------------------------- MAC
   // r_k walks 0..IN_SIZE+1: products are formed for k<IN_SIZE, accumulated
   // one cycle later (k=1..IN_SIZE), and the result is taken at k=IN_SIZE+1.
   assign w_k_x      = (r_k < K_W'(IN_SIZE)) ? X_W'(r_k) : '0;
   assign w_w_rd     = r_base + WA_W'(w_k_x);
   assign w_xe       = P_W'(r_x[w_k_x]);
   assign w_we       = P_W'(r_w[w_w_rd]);
   assign w_prod     = w_xe * w_we;
   assign w_prod_ext = ACC_W'(r_prod);
   assign w_acc_rnd  = (ACC_W+1)'(r_acc) + RND;
   assign w_shift    = w_acc_rnd >>> FRAC_W;

   always_comb begin
      w_sat = w_shift[DATA_W-1:0];
      if (w_shift > SAT_MAX)      w_sat = SAT_MAX[DATA_W-1:0];
      else if (w_shift < SAT_MIN) w_sat = SAT_MIN[DATA_W-1:0];
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_cnt    <= '0;
         r_k      <= '0;
         r_row    <= '0;
         r_base   <= '0;
         r_prod   <= '0;
         r_acc    <= '0;
         r_tready <= 1'b0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_tdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_tready <= (w_state_next == S_IDLE) || (w_state_next == S_LOAD_W) ||
                     (w_state_next == S_RECV_VEC);

         // a new error in the same cycle beats the clear
         if (w_err)          r_err <= 1'b1;
         else if (clear_err) r_err <= 1'b0;

         if (w_hs_in) begin
            if (r_state == S_IDLE) r_cnt <= WA_W'(1);
            else                   r_cnt <= r_cnt + WA_W'(1);
         end

         if (r_state != S_COMPUTE && w_state_next == S_COMPUTE) begin
            r_k   <= '0;
            r_acc <= '0;
         end else if (r_state == S_COMPUTE) begin
            r_k <= r_k + K_W'(1);
            if (r_k < K_W'(IN_SIZE)) r_prod <= w_prod;
            if (r_k != '0 && r_k <= K_W'(IN_SIZE)) r_acc <= r_acc + w_prod_ext;
         end

         if (r_state == S_RECV_VEC && w_state_next == S_COMPUTE) begin
            r_row  <= '0;
            r_base <= '0;
         end

         if (r_state == S_COMPUTE && w_state_next == S_SEND) begin
            r_tvalid <= 1'b1;
            r_tdata  <= w_sat;
            r_tlast  <= w_last_row;
         end

         if (r_state == S_SEND && w_hs_out) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            if (!w_last_row) begin
               r_row  <= r_row + R_W'(1);
               r_base <= r_base + WA_W'(IN_SIZE);
            end
         end
      end
   end

endmodule
